mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly downstream of the execute stage: it consumes the EX/MEM register fields, performs load/store transactions on the data-memory port with a ready handshake, aligns and sign/zero-extends load data, and registers the MEM/WB fields for writeback. It stalls the upstream pipeline while a memory access is outstanding. It also signals misaligned, illegal or timed-out accesses as faults.

---
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory handshake, load alignment,
// MEM/WB register and fault reporting (misaligned, illegal, timeout).
// Ports: EX/MEM fields in_*; data-memory port mem_*; stall to upstream;
// registered MEM/WB fields wb_*; registered fault pulse with cause/addr.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  in_ResultSrc,
  input  logic        in_MemWrite,
  input  logic        in_RegWrite,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_pc_cur,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic [1:0]  wb_ResultSrc,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc_cur,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        is_store, is_load, memop;
  logic        illegal, misal, bad, go, abort;
  logic [1:0]  a;
  logic [31:0] sh, ld_data;

  assign a        = in_alu_result[1:0];
  assign is_store = in_MemWrite;
  assign is_load  = ~in_MemWrite & (in_ResultSrc == 2'b01);
  assign memop    = in_valid & (is_store | is_load);

  always_comb begin
    illegal = 1'b1;
    unique case (in_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = is_store;
      default:                illegal = 1'b1;
    endcase
  end

  assign misal = (in_funct3[1:0] == 2'b01 & a[0])
               | (in_funct3[1:0] == 2'b10 & a != 2'b00);

  assign bad   = memop & (illegal | misal);
  assign go    = memop & ~bad;
  assign abort = (state_q == WAIT) & go & ~mem_ready & (cnt_q == TMAX);

  // Request is gated by reset so an in-flight access drops at once.
  assign mem_req  = go & reset;
  assign stall    = mem_req & ~mem_ready & ~abort;
  assign mem_we   = go & is_store;
  assign mem_addr = {in_alu_result[31:2], 2'b00};

  always_comb begin
    mem_wstrb = 4'b0000;
    mem_wdata = in_store_data;
    if (go && is_store) begin
      unique case (1'b1)
        in_funct3 == 3'b000: begin
          mem_wstrb = 4'b0001 << a;
          mem_wdata = {4{in_store_data[7:0]}};
        end
        in_funct3 == 3'b001: begin
          mem_wstrb = a[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{in_store_data[15:0]}};
        end
        default: mem_wstrb = 4'b1111;
      endcase
    end
  end

  assign sh = mem_rdata >> {a, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    if (is_load) begin
      unique case (in_funct3)
        3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
        3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
        3'b010:  ld_data = sh;
        3'b100:  ld_data = {24'h0, sh[7:0]};
        3'b101:  ld_data = {16'h0, sh[15:0]};
        default: ld_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (go && !mem_ready) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (!go || mem_ready || abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid      <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_ResultSrc  <= 2'b00;
      wb_rd         <= 5'd0;
      wb_alu_result <= 32'h0;
      wb_read_data  <= 32'h0;
      wb_pc_cur     <= 32'h0;
      fault         <= 1'b0;
      fault_cause   <= 2'b00;
      fault_addr    <= 32'h0;
    end else if (stall || !in_valid) begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      fault       <= 1'b0;
    end else if (bad || abort) begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      fault       <= 1'b1;
      fault_addr  <= in_alu_result;
      fault_cause <= abort   ? 2'b11 :
                     illegal ? 2'b10 : 2'b01;
    end else begin
      wb_valid      <= 1'b1;
      wb_RegWrite   <= in_RegWrite;
      wb_ResultSrc  <= in_ResultSrc;
      wb_rd         <= in_rd;
      wb_alu_result <= in_alu_result;
      wb_read_data  <= ld_data;
      wb_pc_cur     <= in_pc_cur;
      fault         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (TIMEOUT=4).
// Each scenario task drives vectors and checks against hand-computed values.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_ResultSrc;
  logic        in_MemWrite, in_RegWrite;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result, in_store_data, in_pc_cur;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_RegWrite;
  logic [1:0]  wb_ResultSrc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_cur;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  int errors = 0;
  int checks = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ResultSrc(in_ResultSrc),
    .in_MemWrite(in_MemWrite), .in_RegWrite(in_RegWrite),
    .in_funct3(in_funct3), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_pc_cur(in_pc_cur),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_ResultSrc(wb_ResultSrc), .wb_rd(wb_rd),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_pc_cur(wb_pc_cur),
    .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] rs,
                       input logic mw, input logic rw,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] sd);
    in_valid      = v;
    in_ResultSrc  = rs;
    in_MemWrite   = mw;
    in_RegWrite   = rw;
    in_funct3     = f3;
    in_rd         = rd;
    in_alu_result = alu;
    in_store_data = sd;
    in_pc_cur     = alu ^ 32'h1000_0000;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    mem_rdata = 32'h0;
    step();
    checks++;
    if ({wb_valid, wb_RegWrite, fault, mem_req, stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000",
               {wb_valid, wb_RegWrite, fault, mem_req, stall});
    end
    checks++;
    if ({wb_rd, wb_alu_result, wb_read_data, fault_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data wb_rd=%0d alu=%h rd=%h fa=%h want 0",
               wb_rd, wb_alu_result, wb_read_data, fault_addr);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_load_align();
    drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b000, 5'd3, 32'h103, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'h80FF_1234;
    #1;
    checks++;
    if ({mem_req, stall, mem_we} !== 3'b100) begin
      errors++;
      $display("FAIL lb_req got %b want 100", {mem_req, stall, mem_we});
    end
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_read_data !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb_data got v=%b %h want v=1 ffffff80",
               wb_valid, wb_read_data);
    end
    in_funct3 = 3'b100;
    step();
    checks++;
    if (wb_read_data !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_data got %h want 00000080", wb_read_data);
    end
    idle();
    step();
  endtask

  task automatic test_store_wait();
    int nst = 0;
    int nv = 0;
    drive(1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 5'd0, 32'h202, 32'h0000_ABCD);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_addr !== 32'h200 || mem_wstrb !== 4'b1100 ||
        mem_wdata !== 32'hABCD_ABCD || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL sh_port got a=%h s=%b d=%h we=%b want 200 1100 abcdabcd 1",
               mem_addr, mem_wstrb, mem_wdata, mem_we);
    end
    for (int i = 0; i < 3; i++) begin
      if (stall) nst++;
      step();
      if (wb_valid) nv++;
    end
    checks++;
    if (mem_addr !== 32'h200 || mem_wstrb !== 4'b1100 ||
        mem_wdata !== 32'hABCD_ABCD || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL sh_stable got a=%h s=%b d=%h req=%b",
               mem_addr, mem_wstrb, mem_wdata, mem_req);
    end
    mem_ready = 1'b1;
    #1;
    if (stall) nst++;
    step();
    if (wb_valid) nv++;
    idle();
    step();
    if (wb_valid) nv++;
    checks++;
    if (nst != 3 || nv != 1) begin
      errors++;
      $display("FAIL sh_stall got stall=%0d wbv=%0d want 3 1", nst, nv);
    end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd9, 32'h105, 32'h0);
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mis_req got req=%b stall=%b want 0 0", mem_req, stall);
    end
    step();
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'b01 ||
        fault_addr !== 32'h105 || wb_RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL mis_fault got f=%b c=%b a=%h rw=%b want 1 01 105 0",
               fault, fault_cause, fault_addr, wb_RegWrite);
    end
    drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b011, 5'd9, 32'h108, 32'h0);
    step();
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'b10 || fault_addr !== 32'h108) begin
      errors++;
      $display("FAIL illegal got f=%b c=%b a=%h want 1 10 108",
               fault, fault_cause, fault_addr);
    end
    idle();
    step();
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_pulse got %b want 0", fault);
    end
  endtask

  task automatic test_timeout();
    int nreq = 0;
    logic ab = 1'b0;
    drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd4, 32'h300, 32'h0);
    mem_ready = 1'b0;
    #1;
    while (mem_req && nreq < 10 && !ab) begin
      nreq++;
      ab = ~stall;
      step();
    end
    checks++;
    if (nreq != 5 || !ab) begin
      errors++;
      $display("FAIL to_len got req=%0d abort=%b want 5 1", nreq, ab);
    end
    checks++;
    if (fault !== 1'b1 || fault_cause !== 2'b11 ||
        fault_addr !== 32'h300 || wb_RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL to_fault got f=%b c=%b a=%h rw=%b want 1 11 300 0",
               fault, fault_cause, fault_addr, wb_RegWrite);
    end
    drive(1'b1, 2'b00, 1'b0, 1'b1, 3'b000, 5'd11, 32'h77, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL to_next_stall got %b want 0", stall);
    end
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd11 || fault !== 1'b0) begin
      errors++;
      $display("FAIL to_next got v=%b rd=%0d f=%b want 1 11 0",
               wb_valid, wb_rd, fault);
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b00, 1'b0, 1'b1, 3'b000, 5'd7, 32'h42, 32'h0);
    mem_ready = 1'b0;
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_alu_result !== 32'h42 ||
        wb_read_data !== 32'h0 || wb_RegWrite !== 1'b1 ||
        wb_pc_cur !== 32'h1000_0042) begin
      errors++;
      $display("FAIL b2b_alu got v=%b rd=%0d alu=%h rd=%h rw=%b pc=%h",
               wb_valid, wb_rd, wb_alu_result, wb_read_data,
               wb_RegWrite, wb_pc_cur);
    end
    drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd5, 32'h10, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_read_data !== 32'hDEAD_BEEF ||
        wb_ResultSrc !== 2'b01) begin
      errors++;
      $display("FAIL b2b_lw got v=%b rd=%0d data=%h src=%b",
               wb_valid, wb_rd, wb_read_data, wb_ResultSrc);
    end
    drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b101, 5'd6, 32'h12, 32'h0);
    step();
    checks++;
    if (wb_read_data !== 32'h0000_DEAD) begin
      errors++;
      $display("FAIL lhu_hi got %h want 0000dead", wb_read_data);
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd8, 32'h400, 32'h0);
    mem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, stall, wb_valid, fault} !== 4'b0) begin
      errors++;
      $display("FAIL rst_wait got %b want 0000",
               {mem_req, stall, wb_valid, fault});
    end
    drive(1'b1, 2'b01, 1'b0, 1'b1, 3'b010, 5'd8, 32'h100, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_relreq got req=%b stall=%b want 1 0", mem_req, stall);
    end
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_read_data !== 32'h1234_5678 || fault !== 1'b0) begin
      errors++;
      $display("FAIL rst_lw got v=%b d=%h f=%b want 1 12345678 0",
               wb_valid, wb_read_data, fault);
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_load_align();
    test_store_wait();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
